// File: rtl/ads1299_pkg.sv
// ads1299_pkg
// Shared definitions for the ADS1299 frame reader: the ADC word width, the
// sync nibble expected at the top of every status word, and the reader FSM
// state encoding.
package ads1299_pkg;

  localparam int         ADS_WORD_BITS   = 24;
  localparam logic [3:0] ADS_STATUS_SYNC = 4'b1100;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    HOLD
  } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen
// Generates the CPOL=0 SPI clock for the frame reader. One SCLK period is
// CLK_DIV cycles high followed by CLK_DIV cycles low.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   run         in   high for every cycle that the next clk cycle should
//                    belong to the SHIFT phase (look-ahead enable)
//   sclk        out  registered SPI clock, idles at 0
//   sample_tick out  last cycle of the high phase (sample MISO here)
//   period_end  out  last cycle of the low phase
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk,
  output logic sample_tick,
  output logic period_end
);

  localparam int            CW        = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HIGH_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LOW_LAST  = CW'(2 * CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          run_q;

  // Phase counter advance; the first cycle of a run always starts at phase
  // 0 so the very first SCLK period is full length.
  always_comb begin
    cnt_next = '0;
    if (run_q && (cnt != LOW_LAST)) begin
      cnt_next = cnt + CW'(1);
    end
  end

  // sclk is computed from the phase the counter is about to enter, so the
  // registered output lines up with cnt and never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
      cnt   <= '0;
      sclk  <= 1'b0;
    end else begin
      run_q <= run;
      cnt   <= run ? cnt_next : '0;
      sclk  <= run && (cnt_next <= HIGH_LAST);
    end
  end

  assign sample_tick = run_q && (cnt == HIGH_LAST);
  assign period_end  = run_q && (cnt == LOW_LAST);

endmodule

// File: rtl/ads1299_frame_reader.sv
// ads1299_frame_reader
// SPI master that reads one RDATAC conversion frame from an ADS1299 after
// every DRDY falling edge, extracts channel CH_SEL and presents it as a
// sign-extended sample with a one-cycle valid strobe.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   enable    in   when low, new DRDY edges are ignored
//   drdy_n    in   ADS1299 DRDY (asynchronous)
//   miso      in   ADS1299 DOUT (asynchronous)
//   sclk      out  SPI clock, CPOL=0
//   cs_n      out  chip select, active low
//   x         out  selected channel, sign-extended to Q_out bits
//   x_valid   out  one-cycle strobe, x valid in the same cycle
//   status    out  status word of the last frame
//   overrun   out  sticky, DRDY fell while a frame was in progress
//   busy      out  high whenever the FSM is not in IDLE
//   frame_err out  (only with ADS1299_STATUS_CHECK_EN) one-cycle pulse when
//                  the status sync nibble is wrong; x_valid is suppressed
//
// Optional feature macro: ADS1299_STATUS_CHECK_EN
module ads1299_frame_reader
  import ads1299_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int N_CH    = 8,
  parameter int CH_SEL  = 0,
  parameter int Q_out   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     drdy_n,
  input  logic                     miso,
  output logic                     sclk,
  output logic                     cs_n,
  output logic [Q_out-1:0]         x,
  output logic                     x_valid,
  output logic [ADS_WORD_BITS-1:0] status,
  output logic                     overrun,
  output logic                     busy
`ifdef ADS1299_STATUS_CHECK_EN
  ,
  output logic                     frame_err
`endif
);

  localparam int             WW          = $clog2(CLK_DIV + 1);
  localparam int             WCW         = $clog2(N_CH + 2);
  localparam logic [WW-1:0]  WAIT_LAST   = WW'(CLK_DIV - 1);
  localparam logic [WCW-1:0] STATUS_WORD = '0;
  localparam logic [WCW-1:0] SEL_WORD    = WCW'(CH_SEL + 1);
  localparam logic [WCW-1:0] LAST_WORD   = WCW'(N_CH + 1);
  localparam logic [4:0]     BIT_LAST    = 5'(ADS_WORD_BITS - 1);

  state_t state;
  state_t next_state;

  logic drdy_meta, drdy_sync, drdy_prev;
  logic miso_meta, miso_sync;
  logic drdy_fall;

  logic sample_tick;
  logic period_end;

  logic [WW-1:0]              wait_cnt;
  logic [4:0]                 bit_cnt;
  logic [WCW-1:0]             word_cnt;
  logic [ADS_WORD_BITS-2:0]   shreg;
  logic [ADS_WORD_BITS-1:0]   word;
  logic [ADS_WORD_BITS-1:0]   hold_word;

  // Two-flop synchronisers. DRDY idles high, so its flops reset to 1 to
  // avoid a false falling edge right after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drdy_meta <= 1'b1;
      drdy_sync <= 1'b1;
      drdy_prev <= 1'b1;
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      drdy_meta <= drdy_n;
      drdy_sync <= drdy_meta;
      drdy_prev <= drdy_sync;
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  assign drdy_fall = drdy_prev && !drdy_sync;
  assign word      = {shreg, miso_sync};
  assign busy      = (state != IDLE);

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .run        (next_state == SHIFT),
    .sclk       (sclk),
    .sample_tick(sample_tick),
    .period_end (period_end)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The frame ends on the low phase that follows the
  // sample of the final bit, i.e. once every word has been counted.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (drdy_fall && enable)                  next_state = SETUP;
      SETUP:   if (wait_cnt == WAIT_LAST)                next_state = SHIFT;
      SHIFT:   if (period_end && (word_cnt == LAST_WORD)) next_state = DONE;
      DONE:                                              next_state = HOLD;
      HOLD:    if (wait_cnt == WAIT_LAST)                next_state = IDLE;
      default:                                           next_state = IDLE;
    endcase
  end

  // Datapath: chip select, SETUP/HOLD timer, MSB-first shift register with
  // word capture, sticky overrun and the output sample. A DRDY edge seen in
  // HOLD (including its final cycle) is an overrun because the FSM only
  // accepts edges while it is already in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n      <= 1'b1;
      x         <= '0;
      x_valid   <= 1'b0;
      status    <= '0;
      overrun   <= 1'b0;
      wait_cnt  <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      shreg     <= '0;
      hold_word <= '0;
`ifdef ADS1299_STATUS_CHECK_EN
      frame_err <= 1'b0;
`endif
    end else begin
      x_valid <= 1'b0;
`ifdef ADS1299_STATUS_CHECK_EN
      frame_err <= 1'b0;
`endif
      cs_n <= !((next_state == SETUP) || (next_state == SHIFT));

      if (drdy_fall && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      if ((next_state != state) || !((state == SETUP) || (state == HOLD))) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + WW'(1);
      end

      if (state == IDLE) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end

      if (sample_tick) begin
        shreg <= word[ADS_WORD_BITS-2:0];
        if (bit_cnt == BIT_LAST) begin
          bit_cnt  <= '0;
          word_cnt <= word_cnt + WCW'(1);
          if (word_cnt == STATUS_WORD) begin
            status <= word;
          end
          if (word_cnt == SEL_WORD) begin
            hold_word <= word;
          end
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end

      if (state == DONE) begin
`ifdef ADS1299_STATUS_CHECK_EN
        if (status[ADS_WORD_BITS-1 -: 4] != ADS_STATUS_SYNC) begin
          frame_err <= 1'b1;
        end else begin
          x       <= Q_out'($signed(hold_word));
          x_valid <= 1'b1;
        end
`else
        x       <= Q_out'($signed(hold_word));
        x_valid <= 1'b1;
`endif
      end
    end
  end

endmodule
